// File: rtl/dsp_frame_sched.sv
// Shares one single-channel DSP core between the left and right audio channels,
// buffering one extra frame. Define SCHED_TIMEOUT_EN to add a DSP-result watchdog.
module dsp_frame_sched #(
  parameter int WIDTH       = 16,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             sclk_i,
  input  logic             rst_n_i,
  input  logic             rx_valid_i,
  input  logic [WIDTH-1:0] rx_left_i,
  input  logic [WIDTH-1:0] rx_right_i,
  output logic             dsp_req_o,
  output logic             dsp_chan_o,
  output logic [WIDTH-1:0] dsp_data_o,
  input  logic             dsp_ready_i,
  input  logic             dsp_done_i,
  input  logic [WIDTH-1:0] dsp_result_i,
  output logic [WIDTH-1:0] tx_left_o,
  output logic [WIDTH-1:0] tx_right_o,
  output logic             tx_load_o,
  output logic             busy_o,
  output logic             overrun_o,
  input  logic             ovr_clr_i,
  output logic             timeout_o,
  output logic [CNT_W-1:0] frame_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ_L, S_WAIT_L, S_REQ_R, S_WAIT_R, S_LOAD
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   cur_l_q, cur_l_d, cur_r_q, cur_r_d;
  logic               pend_vld_q, pend_vld_d;
  logic [WIDTH-1:0]   pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic [WIDTH-1:0]   res_l_q, res_l_d;
  logic [WIDTH-1:0]   tx_l_q, tx_l_d, tx_r_q, tx_r_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovr_q, ovr_d, ovr_set;
  logic               wait_st, done_eff;
  logic [WIDTH-1:0]   res_eff;

  assign wait_st = (state_q == S_WAIT_L) || (state_q == S_WAIT_R);

`ifdef SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wdog_q, wdog_d;
  logic          to_q, to_d, expired;

  // A stalled DSP is bypassed: the raw sample stands in for the missing result.
  assign expired  = wait_st && !dsp_done_i && (wdog_q == TW'(TIMEOUT_CYC - 1));
  assign done_eff = dsp_done_i || expired;
  assign res_eff  = dsp_done_i ? dsp_result_i
                  : ((state_q == S_WAIT_L) ? cur_l_q : cur_r_q);
  assign wdog_d   = wait_st ? wdog_q + TW'(1) : '0;
  assign to_d     = expired || (to_q && !ovr_clr_i);
  assign timeout_o = to_q;

  always_ff @(posedge sclk_i) begin
    if (!rst_n_i) begin
      wdog_q <= '0;
      to_q   <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      to_q   <= to_d;
    end
  end
`else
  assign done_eff  = dsp_done_i;
  assign res_eff   = dsp_result_i;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (pend_vld_q || rx_valid_i) state_d = S_REQ_L;
      S_REQ_L:  if (dsp_ready_i)              state_d = S_WAIT_L;
      S_WAIT_L: if (done_eff)                 state_d = S_REQ_R;
      S_REQ_R:  if (dsp_ready_i)              state_d = S_WAIT_R;
      S_WAIT_R: if (done_eff)                 state_d = S_LOAD;
      S_LOAD:                                 state_d = S_IDLE;
      default:                                state_d = S_IDLE;
    endcase
  end

  // NOTE: every variable gets a hold default first so no path can infer a latch.
  always_comb begin
    cur_l_d    = cur_l_q;
    cur_r_d    = cur_r_q;
    pend_vld_d = pend_vld_q;
    pend_l_d   = pend_l_q;
    pend_r_d   = pend_r_q;
    res_l_d    = res_l_q;
    tx_l_d     = tx_l_q;
    tx_r_d     = tx_r_q;
    cnt_d      = cnt_q;
    ovr_set    = 1'b0;

    if (state_q == S_IDLE) begin
      if (pend_vld_q) begin
        cur_l_d    = pend_l_q;
        cur_r_d    = pend_r_q;
        pend_vld_d = rx_valid_i;
        if (rx_valid_i) begin
          pend_l_d = rx_left_i;
          pend_r_d = rx_right_i;
        end
      end else if (rx_valid_i) begin
        cur_l_d = rx_left_i;
        cur_r_d = rx_right_i;
      end
    end else if (rx_valid_i) begin
      if (pend_vld_q) begin
        ovr_set = 1'b1;
      end else begin
        pend_vld_d = 1'b1;
        pend_l_d   = rx_left_i;
        pend_r_d   = rx_right_i;
      end
    end

    if (state_q == S_WAIT_L && done_eff) res_l_d = res_eff;
    if (state_q == S_WAIT_R && done_eff) begin
      tx_l_d = res_l_q;
      tx_r_d = res_eff;
    end
    if (state_q == S_LOAD) cnt_d = cnt_q + CNT_W'(1);
  end

  assign ovr_d = ovr_set || (ovr_q && !ovr_clr_i);

  // NOTE: data registers are reset as well, since every output must read 0 after reset.
  always_ff @(posedge sclk_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      cur_l_q    <= '0;
      cur_r_q    <= '0;
      pend_vld_q <= 1'b0;
      pend_l_q   <= '0;
      pend_r_q   <= '0;
      res_l_q    <= '0;
      tx_l_q     <= '0;
      tx_r_q     <= '0;
      cnt_q      <= '0;
      ovr_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so all flops sample pre-edge values together.
      state_q    <= state_d;
      cur_l_q    <= cur_l_d;
      cur_r_q    <= cur_r_d;
      pend_vld_q <= pend_vld_d;
      pend_l_q   <= pend_l_d;
      pend_r_q   <= pend_r_d;
      res_l_q    <= res_l_d;
      tx_l_q     <= tx_l_d;
      tx_r_q     <= tx_r_d;
      cnt_q      <= cnt_d;
      ovr_q      <= ovr_d;
    end
  end

  always_comb begin
    dsp_req_o  = (state_q == S_REQ_L) || (state_q == S_REQ_R);
    dsp_chan_o = (state_q == S_REQ_R);
    dsp_data_o = '0;
    if (state_q == S_REQ_L) dsp_data_o = cur_l_q;
    if (state_q == S_REQ_R) dsp_data_o = cur_r_q;
    tx_load_o  = (state_q == S_LOAD);
    busy_o     = (state_q != S_IDLE);
  end

  assign tx_left_o   = tx_l_q;
  assign tx_right_o  = tx_r_q;
  assign overrun_o   = ovr_q;
  assign frame_cnt_o = cnt_q;

endmodule

// File: doc/dsp_frame_sched.md
Name: dsp_frame_sched

Overview:
Sequences one shared single-channel DSP core across the left and right audio channels. It sits between the I2S receiver and the I2S transmitter. It latches each received stereo frame and issues the left sample to the DSP, then the right. It collects both results and presents them as one coherent frame to the transmitter with a load strobe. It also buffers one frame that arrives while busy and flags overruns.

Parameters:
WIDTH, 16, sample width in bits (rx, DSP and tx data).
CNT_W, 16, width of the completed-frame counter.
TIMEOUT_CYC, 64, DSP result watchdog limit in sclk_i cycles (used only with SCHED_TIMEOUT_EN).

Ports:
sclk_i  in  1  sole clock; all logic on its rising edge.
rst_n_i  in  1  reset; synchronous, active-low.
rx_valid_i  in  1  one-cycle pulse: new stereo frame on rx_left_i/rx_right_i.
rx_left_i  in  WIDTH  received left sample.
rx_right_i  in  WIDTH  received right sample.
dsp_req_o  out  1  request to DSP; data/chan held stable while high.
dsp_chan_o  out  1  0=left, 1=right.
dsp_data_o  out  WIDTH  sample to DSP.
dsp_ready_i  in  1  DSP accepts request (transfer when dsp_req_o & dsp_ready_i).
dsp_done_i  in  1  one-cycle pulse: dsp_result_i valid.
dsp_result_i  in  WIDTH  processed sample.
tx_left_o  out  WIDTH  processed left sample to transmitter.
tx_right_o  out  WIDTH  processed right sample to transmitter.
tx_load_o  out  1  one-cycle pulse: tx_left_o/tx_right_o hold a new frame.
busy_o  out  1  high whenever state != IDLE.
overrun_o  out  1  sticky: a frame was dropped.
ovr_clr_i  in  1  clears overrun_o.
timeout_o  out  1  sticky watchdog flag (see Optional Feature).
frame_cnt_o  out  CNT_W  count of tx_load_o pulses; wraps at 2^CNT_W.

Behaviour:
- Reset (rst_n_i=0 at an edge):
  - state=IDLE and pending buffer empty.
  - All outputs are 0, including data, counter and sticky flags.
  - Reset mid-operation abandons the frame; dsp_req_o is low after that edge.
- State machine: IDLE -> REQ_L -> WAIT_L -> REQ_R -> WAIT_R -> LOAD -> IDLE.
- IDLE:
  - If the pending buffer is full, move it to the current registers, empty pending, go to REQ_L.
  - Otherwise, if rx_valid_i, latch the rx samples into the current registers and go to REQ_L.
- REQ_L / REQ_R:
  - dsp_req_o=1, dsp_chan_o=0/1, dsp_data_o=current left/right sample.
  - On dsp_ready_i go to WAIT_L / WAIT_R; dsp_req_o drops in the next cycle.
- WAIT_L: on dsp_done_i capture dsp_result_i into the left result register, go to REQ_R.
- WAIT_R:
  - On dsp_done_i, load tx_left_o from the left result and tx_right_o from dsp_result_i, go to LOAD.
- LOAD: tx_load_o=1 for exactly this cycle; frame_cnt_o increments; go to IDLE.
- dsp_done_i outside WAIT states and dsp_ready_i outside REQ states are ignored.
- tx_left_o/tx_right_o hold their values until the next LOAD.
- Minimum latency (dsp_ready_i tied high, done 1 cycle after accept): rx_valid_i at cycle 0 -> dsp_req_o at cycle 1 -> tx_load_o at cycle 5.
- Back-to-back throughput is one frame per 6 cycles minimum; this includes the IDLE cycle.
- Pending buffer (one frame deep):
  - rx_valid_i while not IDLE: store into pending if empty.
  - If pending is full: drop the new frame (pending keeps the older one) and set overrun_o.
  - rx_valid_i in IDLE with pending full: pending goes to current, the new frame goes to pending; no overrun.
- overrun_o is cleared by ovr_clr_i; if set and clear occur in the same cycle, set wins.
- No arithmetic on samples; data passes unmodified at WIDTH bits.

Optional Feature:
- Macro: SCHED_TIMEOUT_EN.
- When defined:
  - A counter runs in WAIT_L/WAIT_R, reset on entry to each WAIT state.
  - If it reaches TIMEOUT_CYC without dsp_done_i, the unprocessed current sample is used as the result and the FSM advances as if done had arrived.
  - timeout_o is set sticky and is cleared by ovr_clr_i (set wins).
- When undefined: no counter; WAIT states wait indefinitely; timeout_o is tied 0.

Test Plan:
- Reset, then rx_valid_i with L=16'h1234, R=16'hABCD; DSP returns input+1 with ready high and done 1 cycle later -> dsp_chan_o sequence 0 then 1; tx_load_o at cycle 5 with tx_left_o=16'h1235, tx_right_o=16'hABCE; frame_cnt_o=1.
- Hold dsp_ready_i low for 10 cycles in REQ_L -> dsp_req_o stays high and dsp_data_o=16'h1234 stable throughout; single transfer on ready.
- Three rx_valid_i pulses (frames A, B, C) during one busy frame -> outputs A then B; C dropped; overrun_o=1; ovr_clr_i pulse -> 0.
- Assert rst_n_i=0 during WAIT_R -> next cycle busy_o=0, dsp_req_o=0, tx_*=0, frame_cnt_o=0; no tx_load_o.
- With SCHED_TIMEOUT_EN and TIMEOUT_CYC=8, withhold dsp_done_i -> after 8 WAIT cycles the left output equals the raw input 16'h1234 and timeout_o=1; without the macro busy_o remains high.
- Send 2^CNT_W+1 frames (CNT_W=4) -> frame_cnt_o wraps to 1.
